// File: rtl/fpu_issue_ctl.sv
// Issue sequencer for the multi-cycle FP units.
// Freezes the pipeline while an FP op is in flight and captures its result.
module fpu_issue_ctl #(
  parameter int L1_CYC = 1,
  parameter int L2_CYC = 2,
  parameter int L3_CYC = 3,
  parameter int CNT_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [5:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic        n_stall,
  input  logic        flush,
  input  logic [31:0] unit_res,
  output logic [5:0]  op_hold,
  output logic        alu_nstall,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_cnt;
  logic             lat_ok;
  logic             accept;

  // latency class decode: countdown preload for the issued op
  always_comb begin
    lat_ok  = 1'b1;
    lat_cnt = '0;
    case (issue_op)
      6'b010110, 6'b010111,
      6'b011001, 6'b011010:
        lat_cnt = CNT_W'(L1_CYC - 1);
      6'b010000, 6'b010001,
      6'b010010, 6'b010100:
        lat_cnt = CNT_W'(L2_CYC - 1);
      6'b010011:
        lat_cnt = CNT_W'(L3_CYC - 1);
      default:
        lat_ok = 1'b0;
    endcase
  end

  // accept gates the freeze in the issue cycle itself
  always_comb begin
    accept = (state == IDLE) & issue_valid & lat_ok
           & ~flush & ~rst;
    alu_nstall = ~(accept |
                   ((state == EXEC) && (cnt != '0)));
  end

  assign busy = (state == EXEC);

  // sequencer, result capture and stall statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_hold   <= '0;
      busy_rd   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      stall_cnt <= '0;
    end else begin
      res_valid <= 1'b0;
      if (!alu_nstall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      case (state)
        IDLE: begin
          if (accept) begin
            op_hold <= issue_op;
            busy_rd <= issue_rd;
            cnt     <= lat_cnt;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_data  <= unit_res;
            res_rd    <= busy_rd;
            res_valid <= 1'b1;
            state     <= n_stall ? IDLE : DONE;
          end
        end
        DONE: begin
          if (flush || n_stall)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
